// File: rtl/sized_data_memory.sv
// Byte-addressable data memory with sized loads/stores, sign/zero extension and fault flags.
// Latency: one cycle; a request accepted on edge N is answered in cycle N..N+1 with registered outputs.
// Backpressure: req_ready is low while the memory self-initialises; responses are never stalled.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid / req_ready      request handshake (ready = 1 only in RUN)
//   req_write, req_addr,       store/load select, byte address,
//   req_size, req_unsigned,    size (1 << size bytes), zero-extend select,
//   req_wdata                  store data (low bytes used)
//   resp_valid, resp_rdata,    one-cycle response pulse, extended load data,
//   resp_misaligned, resp_oob  fault flags
module sized_data_memory #(
    parameter int XLEN        = 64,
    parameter int DEPTH_BYTES = 256,
    parameter int AW          = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [AW-1:0]   req_addr,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_misaligned,
    output logic            resp_oob
);

    localparam int IW = $clog2(DEPTH_BYTES);
    localparam int NB = XLEN / 8;
    localparam logic [AW-1:0] DEPTH_AW = AW'(DEPTH_BYTES);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      mem [DEPTH_BYTES];

    logic            accept;
    logic            mis;
    logic            oob;
    logic            fault;
    logic            do_write;
    logic [AW-1:0]   nbytes;
    logic [IW-1:0]   addr_lo;
    logic [NB-1:0]   be;
    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] ext;
    logic            sgn;

    // ------------------------------------------------------------------
    // Init / run sequencing
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == ST_INIT) begin
            idx_d = idx_q + IW'(1);
            if (idx_q == IW'(DEPTH_BYTES - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    assign req_ready = (state_q == ST_RUN);
    assign accept    = req_valid & req_ready;

    // ------------------------------------------------------------------
    // Fault detection
    // ------------------------------------------------------------------
    assign nbytes  = AW'(1) << req_size;
    assign addr_lo = req_addr[IW-1:0];

    always_comb begin
        mis = 1'b0;
        case (req_size)
            2'd0: mis = 1'b0;
            2'd1: mis = req_addr[0];
            2'd2: mis = |req_addr[1:0];
            2'd3: mis = |req_addr[2:0];
            default: mis = 1'b0;
        endcase
    end

    // addr + nbytes > DEPTH rewritten as addr > DEPTH - nbytes so the full
    // address width is compared without an overflowing sum; DEPTH >= 8
    // guarantees the subtraction never goes negative.
    assign oob      = req_addr > (DEPTH_AW - nbytes);
    assign fault    = mis | oob;
    assign do_write = accept & req_write & ~fault;

    // ------------------------------------------------------------------
    // Byte enables, read gather and extension
    // ------------------------------------------------------------------
    always_comb begin
        be  = '0;
        raw = '0;
        for (int k = 0; k < NB; k++) begin
            be[k] = (k < (1 << req_size));
            if (be[k]) begin
                raw[8*k +: 8] = mem[addr_lo + IW'(k)];
            end
        end
    end

    assign sgn = ~req_unsigned;

    always_comb begin
        ext = raw;
        case (req_size)
            2'd0: ext = {{(XLEN-8){sgn & raw[7]}},   raw[7:0]};
            2'd1: ext = {{(XLEN-16){sgn & raw[15]}}, raw[15:0]};
            2'd2: ext = {{(XLEN-32){sgn & raw[31]}}, raw[31:0]};
            default: ext = raw;
        endcase
    end

    // ------------------------------------------------------------------
    // State and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_INIT;
            idx_q           <= '0;
            resp_valid      <= 1'b0;
            resp_rdata      <= '0;
            resp_misaligned <= 1'b0;
            resp_oob        <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            resp_valid      <= accept;
            resp_rdata      <= (accept && !req_write && !fault) ? ext : '0;
            resp_misaligned <= accept & mis;
            resp_oob        <= accept & oob;
        end
    end

    // Storage has no reset: the INIT sweep provides the defined contents.
    // The read above samples the array before this edge's update, but a
    // store at edge N is already visible to a load accepted at edge N+1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == ST_INIT) begin
                mem[idx_q] <= 8'(idx_q);
            end else if (do_write) begin
                for (int k = 0; k < NB; k++) begin
                    if (be[k]) begin
                        mem[addr_lo + IW'(k)] <= req_wdata[8*k +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sized_data_memory.sv
module tb_sized_data_memory;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_oob;

    sized_data_memory #(.XLEN(64), .DEPTH_BYTES(256), .AW(64)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .resp_oob        (resp_oob)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rdata;
        logic        mis;
        logic        oob;
        int          cyc;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   nid    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Issue one request at the falling edge; it is accepted on the next rising edge.
    task automatic send(input logic wr, input logic [63:0] addr, input logic [1:0] sz,
                        input logic uns, input logic [63:0] wd,
                        input logic [63:0] er, input logic em, input logic eo);
        exp_t e;
        @(negedge clk);
        req_valid    = 1'b1;
        req_write    = wr;
        req_addr     = addr;
        req_size     = sz;
        req_unsigned = uns;
        req_wdata    = wd;
        e.rdata = er;
        e.mis   = em;
        e.oob   = eo;
        e.cyc   = cyc + 1;
        e.id    = nid;
        nid++;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    // Counts rising edges from reset release until req_ready is seen high.
    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!req_ready && n < 2000);
    endtask

    // Response monitor / scoreboard
    always @(negedge clk) begin
        if (resp_valid) begin
            if (sb.size() == 0) begin
                check_val("unexpected_resp", 64'(resp_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val($sformatf("r%0d_rdata", e.id), resp_rdata, e.rdata);
                check_val($sformatf("r%0d_mis", e.id), 64'(resp_misaligned), 64'(e.mis));
                check_val($sformatf("r%0d_oob", e.id), 64'(resp_oob), 64'(e.oob));
                check_val($sformatf("r%0d_lat", e.id), 64'(cyc), 64'(e.cyc));
            end
        end else if (req_ready) begin
            check_val("idle_outputs", {resp_rdata[61:0], resp_misaligned, resp_oob}, 64'd0);
        end
    end

    int n;

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = '0;
        req_size     = '0;
        req_unsigned = 1'b0;
        req_wdata    = '0;

        repeat (3) @(negedge clk);
        check_val("rst_ready", 64'(req_ready), 64'd0);
        check_val("rst_valid", 64'(resp_valid), 64'd0);
        check_val("rst_rdata", resp_rdata, 64'd0);
        check_val("rst_flags", {62'd0, resp_misaligned, resp_oob}, 64'd0);

        // Reset pulse at init index 100 must restart the full sweep.
        reset = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        check_val("midinit_ready", 64'(req_ready), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_ready(n);
        check_val("init_cycles", 64'(n), 64'd256);

        //    wr    addr                   sz    uns   wdata                  exp rdata              mis   oob
        send(1'b0, 64'h00,                2'd3, 1'b0, 64'h0,                 64'h0706050403020100, 1'b0, 1'b0);
        send(1'b0, 64'h80,                2'd0, 1'b0, 64'h0,                 64'hFFFFFFFFFFFFFF80, 1'b0, 1'b0);
        send(1'b0, 64'h80,                2'd0, 1'b1, 64'h0,                 64'h0000000000000080, 1'b0, 1'b0);
        send(1'b0, 64'hFE,                2'd1, 1'b0, 64'h0,                 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b0);
        send(1'b0, 64'h80,                2'd1, 1'b1, 64'h0,                 64'h0000000000008180, 1'b0, 1'b0);
        send(1'b0, 64'h84,                2'd2, 1'b0, 64'h0,                 64'hFFFFFFFF87868584, 1'b0, 1'b0);
        send(1'b0, 64'h64,                2'd0, 1'b1, 64'h0,                 64'h0000000000000064, 1'b0, 1'b0);
        send(1'b1, 64'h10,                2'd2, 1'b0, 64'h12345678DEADBEEF,  64'h0,                1'b0, 1'b0);
        send(1'b0, 64'h10,                2'd3, 1'b0, 64'h0,                 64'h17161514DEADBEEF, 1'b0, 1'b0);
        send(1'b0, 64'h14,                2'd0, 1'b1, 64'h0,                 64'h0000000000000014, 1'b0, 1'b0);
        send(1'b1, 64'h03,                2'd1, 1'b0, 64'hAAAA,              64'h0,                1'b1, 1'b0);
        send(1'b0, 64'h03,                2'd0, 1'b1, 64'h0,                 64'h0000000000000003, 1'b0, 1'b0);
        send(1'b0, 64'hFC,                2'd3, 1'b0, 64'h0,                 64'h0,                1'b1, 1'b1);
        send(1'b0, 64'h100,               2'd0, 1'b0, 64'h0,                 64'h0,                1'b0, 1'b1);
        send(1'b0, 64'hF8,                2'd3, 1'b0, 64'h0,                 64'hFFFEFDFCFBFAF9F8, 1'b0, 1'b0);
        send(1'b0, 64'hFFFFFFFFFFFFFFFC,  2'd2, 1'b0, 64'h0,                 64'h0,                1'b0, 1'b1);
        send(1'b1, 64'hFC,                2'd3, 1'b0, 64'h1111111111111111,  64'h0,                1'b1, 1'b1);
        send(1'b0, 64'hFC,                2'd2, 1'b1, 64'h0,                 64'h00000000FFFEFDFC, 1'b0, 1'b0);
        send(1'b1, 64'h21,                2'd0, 1'b0, 64'hFFFFFFFFFFFFFF5A,  64'h0,                1'b0, 1'b0);
        send(1'b0, 64'h20,                2'd2, 1'b0, 64'h0,                 64'h23225A20,         1'b0, 1'b0);
        idle(4);

        // Reset in RUN coincident with a request: nothing is answered.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 64'h10;
        req_size  = 2'd3;
        reset     = 1'b1;
        @(negedge clk);
        check_val("run_rst_valid", 64'(resp_valid), 64'd0);
        check_val("run_rst_ready", 64'(req_ready), 64'd0);
        req_valid = 1'b0;
        reset     = 1'b0;
        wait_ready(n);
        check_val("reinit_cycles", 64'(n), 64'd256);

        // INIT rewrote the earlier store.
        send(1'b0, 64'h10, 2'd3, 1'b0, 64'h0, 64'h1716151413121110, 1'b0, 1'b0);
        idle(4);

        check_val("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before limit");
        $fatal(1);
    end

endmodule
